cargador_instrucciones: RTL and testbench

Program loader that fills the instruction memory read by fetch, decode and immediate generation. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words. Each word is written to consecutive word addresses of the instruction memory, and a trailing XOR checksum byte is verified. The processor is held in reset until a load completes.

---
 rtl/cargador_instrucciones_pkg.sv | 25 ++
 rtl/cargador_instrucciones.sv | 123 ++++++++++++
 tb/tb_cargador_instrucciones.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cargador_instrucciones_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// fixed word geometry and the byte-insert helper used by the packer.
package cargador_instrucciones_pkg;

   typedef enum logic [2:0] {
      REPOSO   = 3'd0,
      RECIBE   = 3'd1,
      ESCRIBE  = 3'd2,
      VERIFICA = 3'd3,
      FIN      = 3'd4
   } estado_t;

   localparam int BYTES_POR_PALABRA = 4;

   // Byte k lands in bits [8k+7:8k], giving little-endian packing.
   function automatic logic [31:0] insertar_byte(input logic [31:0] palabra,
                                                 input logic [7:0]  dato,
                                                 input logic [1:0]  k);
      logic [31:0] r;
      r = palabra;
      r[{k, 3'b000} +: 8] = dato;
      return r;
   endfunction

endpackage

// File: rtl/cargador_instrucciones.sv
// Program loader: packs a byte stream into 32-bit words, writes them to
// consecutive instruction-memory addresses and verifies a trailing XOR checksum.
module cargador_instrucciones
   import cargador_instrucciones_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inicio_i,
   input  logic [ADDR_W:0]   longitud_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valido_i,
   output logic              byte_listo_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_dir_o,
   output logic [31:0]       mem_dato_o,
   output logic              cpu_rst_o,
   output logic              ocupado_o,
   output logic              terminado_o,
   output logic              error_o
);

   localparam logic [ADDR_W:0] CAPACIDAD = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] UNO       = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [1:0]      ULTIMO    = 2'(BYTES_POR_PALABRA - 1);

   estado_t         estado;
   logic [ADDR_W:0] longitud;
   logic [ADDR_W:0] cuenta;
   logic [1:0]      indice;
   logic [7:0]      suma;
   logic [31:0]     palabra;
   logic            acepta;
   logic            suma_mal;

   assign acepta   = byte_valido_i & byte_listo_o;
   assign suma_mal = (byte_i != suma);

   // Loader FSM; every output is registered so byte_listo_o depends on state only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         estado       <= REPOSO;
         longitud     <= '0;
         cuenta       <= '0;
         indice       <= 2'd0;
         suma         <= 8'h00;
         palabra      <= 32'h0000_0000;
         byte_listo_o <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_dir_o    <= '0;
         mem_dato_o   <= 32'h0000_0000;
         cpu_rst_o    <= 1'b1;
         ocupado_o    <= 1'b0;
         terminado_o  <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         mem_we_o <= 1'b0;
         case (estado)
            REPOSO, FIN: begin
               if (inicio_i) begin
                  longitud  <= longitud_i;
                  cuenta    <= '0;
                  indice    <= 2'd0;
                  suma      <= 8'h00;
                  cpu_rst_o <= 1'b1;
                  if (longitud_i > CAPACIDAD) begin
                     // Illegal length: report failure at once, no writes.
                     estado       <= FIN;
                     byte_listo_o <= 1'b0;
                     ocupado_o    <= 1'b0;
                     terminado_o  <= 1'b1;
                     error_o      <= 1'b1;
                  end else begin
                     estado       <= (longitud_i == '0) ? VERIFICA : RECIBE;
                     byte_listo_o <= 1'b1;
                     ocupado_o    <= 1'b1;
                     terminado_o  <= 1'b0;
                     error_o      <= 1'b0;
                  end
               end
            end
            RECIBE: begin
               if (acepta) begin
                  palabra <= insertar_byte(palabra, byte_i, indice);
                  suma    <= suma ^ byte_i;
                  indice  <= indice + 2'd1;
                  if (indice == ULTIMO) begin
                     estado       <= ESCRIBE;
                     byte_listo_o <= 1'b0;
                     mem_we_o     <= 1'b1;
                     mem_dir_o    <= cuenta[ADDR_W-1:0];
                     mem_dato_o   <= insertar_byte(palabra, byte_i, indice);
                  end
               end
            end
            ESCRIBE: begin
               // cuenta is one bit wider than the address so a full memory never wraps.
               cuenta       <= cuenta + UNO;
               byte_listo_o <= 1'b1;
               estado       <= ((cuenta + UNO) == longitud) ? VERIFICA : RECIBE;
            end
            VERIFICA: begin
               if (acepta) begin
                  estado       <= FIN;
                  byte_listo_o <= 1'b0;
                  ocupado_o    <= 1'b0;
                  terminado_o  <= 1'b1;
                  error_o      <= suma_mal;
                  cpu_rst_o    <= suma_mal;
               end
            end
            default: begin
               estado       <= REPOSO;
               byte_listo_o <= 1'b0;
               ocupado_o    <= 1'b0;
               cpu_rst_o    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Scoreboard bench for cargador_instrucciones with a small (ADDR_W=2) memory
// so both full-capacity and illegal lengths are reachable.
module tb_cargador_instrucciones;

   localparam int AW  = 2;
   localparam int LW  = AW + 1;
   localparam int CAP = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] dir;
      logic [31:0]   dato;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          inicio;
   logic [LW-1:0] longitud;
   logic [7:0]    byte_in;
   logic          byte_valido;
   logic          byte_listo_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_dir_o;
   logic [31:0]   mem_dato_o;
   logic          cpu_rst_o;
   logic          ocupado_o;
   logic          terminado_o;
   logic          error_o;

   int   checks   = 0;
   int   failures = 0;
   wr_t  exp_wr[$];
   logic exp_done[$];
   logic [31:0] palabras[$];

   cargador_instrucciones #(.ADDR_W(AW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .inicio_i     (inicio),
      .longitud_i   (longitud),
      .byte_i       (byte_in),
      .byte_valido_i(byte_valido),
      .byte_listo_o (byte_listo_o),
      .mem_we_o     (mem_we_o),
      .mem_dir_o    (mem_dir_o),
      .mem_dato_o   (mem_dato_o),
      .cpu_rst_o    (cpu_rst_o),
      .ocupado_o    (ocupado_o),
      .terminado_o  (terminado_o),
      .error_o      (error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT writes or finishes a load.
   initial begin
      logic prev_start;
      logic prev_term;
      wr_t  w;
      logic e;
      prev_start = 1'b0;
      prev_term  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_start = 1'b0;
            prev_term  = 1'b0;
         end else begin
            if (mem_we_o) begin
               chk("write_expected", 32'(exp_wr.size() > 0), 32'd1);
               chk("listo_low_in_write", 32'(byte_listo_o), 32'd0);
               if (exp_wr.size() > 0) begin
                  w = exp_wr.pop_front();
                  chk("write_addr", 32'(mem_dir_o), 32'(w.dir));
                  chk("write_data", mem_dato_o, w.dato);
               end
            end
            if (terminado_o && (prev_start || !prev_term)) begin
               chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
               chk("done_ocupado", 32'(ocupado_o), 32'd0);
               chk("done_listo", 32'(byte_listo_o), 32'd0);
               if (exp_done.size() > 0) begin
                  e = exp_done.pop_front();
                  chk("done_error", 32'(error_o), 32'(e));
                  chk("done_cpu_rst", 32'(cpu_rst_o), 32'(e));
               end
            end else if (prev_start) begin
               chk("start_ocupado", 32'(ocupado_o), 32'd1);
               chk("start_cpu_rst", 32'(cpu_rst_o), 32'd1);
               chk("start_error", 32'(error_o), 32'd0);
            end
            prev_start = inicio && !ocupado_o;
            prev_term  = terminado_o;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      logic ok;
      if (gap > 0) begin
         byte_valido = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      byte_in     = b;
      byte_valido = 1'b1;
      if (noise) begin
         inicio   = 1'b1;
         longitud = LW'($urandom);
      end
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         ok = byte_listo_o;
         @(posedge clk);
         #1;
      end
      inicio = 1'b0;
      chk("byte_accepted", 32'(ok), 32'd1);
   endtask

   // Reference: words go to addresses 0..L-1; error iff length illegal or checksum differs.
   task automatic do_load(input int len, input logic [7:0] mask,
                          input int mingap, input int maxgap, input bit noise);
      logic [7:0] x;
      logic [7:0] c;
      logic       done_seen;
      while (palabras.size() < len) palabras.push_back($urandom);
      x = 8'h00;
      for (int i = 0; i < len; i++)
         x = x ^ palabras[i][7:0] ^ palabras[i][15:8] ^ palabras[i][23:16] ^ palabras[i][31:24];
      c = x ^ mask;
      if (len > CAP) begin
         exp_done.push_back(1'b1);
      end else begin
         for (int i = 0; i < len; i++) exp_wr.push_back('{dir: AW'(i), dato: palabras[i]});
         exp_done.push_back(c != x);
      end
      byte_valido = 1'b0;
      longitud    = LW'(len);
      inicio      = 1'b1;
      @(posedge clk);
      #1;
      inicio = 1'b0;
      if (len > CAP) begin
         repeat (3) @(posedge clk);
         #1;
      end else begin
         for (int i = 0; i < len; i++)
            for (int k = 0; k < 4; k++)
               send_byte(palabras[i][8*k +: 8], $urandom_range(mingap, maxgap),
                         noise && ($urandom_range(0, 3) == 0));
         send_byte(c, $urandom_range(mingap, maxgap), 1'b0);
         done_seen = 1'b0;
         for (int t = 0; t < 20 && !done_seen; t++) begin
            done_seen = terminado_o;
            if (!done_seen) begin
               @(posedge clk);
               #1;
            end
         end
         chk("done_seen", 32'(done_seen), 32'd1);
         byte_in = 8'($urandom);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
         byte_valido = 1'b0;
      end
      palabras.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      inicio      = 1'b0;
      longitud    = '0;
      byte_in     = 8'h00;
      byte_valido = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_listo", 32'(byte_listo_o), 32'd0);
      chk("rst_we", 32'(mem_we_o), 32'd0);
      chk("rst_dir", 32'(mem_dir_o), 32'd0);
      chk("rst_dato", mem_dato_o, 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
      chk("rst_ocupado", 32'(ocupado_o), 32'd0);
      chk("rst_terminado", 32'(terminado_o), 32'd0);
      chk("rst_error", 32'(error_o), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Known program: checksum 0xB6 is the XOR of 13 05 A0 00.
      palabras.push_back(32'h00A0_0513);
      do_load(1, 8'h00, 0, 0, 1'b0);
      do_load(2, 8'h5A, 0, 1, 1'b0);
      do_load(0, 8'h00, 0, 0, 1'b0);
      do_load(0, 8'h01, 0, 0, 1'b0);
      do_load(3, 8'h00, 1, 3, 1'b0);
      do_load(3, 8'h00, 0, 0, 1'b0);
      do_load(5, 8'h00, 0, 0, 1'b0);
      do_load(4, 8'h00, 0, 1, 1'b0);
      do_load(7, 8'h00, 0, 0, 1'b0);

      // Reset after 6 bytes of a two-word load.
      palabras.push_back($urandom);
      palabras.push_back($urandom);
      exp_wr.push_back('{dir: AW'(0), dato: palabras[0]});
      exp_wr.push_back('{dir: AW'(1), dato: palabras[1]});
      exp_done.push_back(1'b0);
      longitud = LW'(2);
      inicio   = 1'b1;
      @(posedge clk);
      #1;
      inicio = 1'b0;
      for (int n = 0; n < 6; n++) send_byte(palabras[n / 4][8*(n % 4) +: 8], 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_listo", 32'(byte_listo_o), 32'd0);
      chk("mid_rst_we", 32'(mem_we_o), 32'd0);
      chk("mid_rst_dir", 32'(mem_dir_o), 32'd0);
      chk("mid_rst_dato", mem_dato_o, 32'd0);
      chk("mid_rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
      chk("mid_rst_ocupado", 32'(ocupado_o), 32'd0);
      chk("mid_rst_terminado", 32'(terminado_o), 32'd0);
      chk("mid_rst_error", 32'(error_o), 32'd0);
      chk("mid_rst_writes_left", 32'(exp_wr.size()), 32'd1);
      exp_wr.delete();
      exp_done.delete();
      palabras.delete();
      byte_valido = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      palabras.push_back(32'hDEAD_BEEF);
      do_load(1, 8'h00, 0, 1, 1'b0);

      for (int r = 0; r < 25; r++)
         do_load($urandom_range(0, (1 << LW) - 1),
                 ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 0, 2, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("writes_pending", 32'(exp_wr.size()), 32'd0);
      chk("dones_pending", 32'(exp_done.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
